// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC stage with start/stall/halt sequencing and a retired-instruction counter.
// Optional misaligned-branch trap enabled by defining MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter int                  PC_WIDTH  = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt_req,
  input  logic                 branch,
  input  logic                 zero,
  input  logic [31:0]          immediate,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 pc_valid,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;

  state_t                state_reg;
  logic [PC_WIDTH-1:0]   pc_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic                  pc_valid_reg;
  logic                  halted_reg;
  logic                  fault_reg;

  logic                  taken;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   branch_raw;
  logic [PC_WIDTH-1:0]   branch_target;
  logic [PC_WIDTH-1:0]   pc_next;
  logic                  misaligned;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  unused_bits;

  assign taken      = branch & zero;
  assign pc_plus4   = pc_reg + PC_WIDTH'(4);
  assign branch_raw = pc_reg + immediate[PC_WIDTH-1:0];

`ifdef MISALIGN_TRAP_EN
  assign branch_target = branch_raw;
  assign misaligned    = taken & (branch_raw[1:0] != 2'b00);
  assign unused_bits   = ^immediate[31:PC_WIDTH];
`else
  // Without the trap, taken targets are silently word-aligned.
  assign branch_target = {branch_raw[PC_WIDTH-1:2], 2'b00};
  assign misaligned    = 1'b0;
  assign unused_bits   = ^{immediate[31:PC_WIDTH], branch_raw[1:0]};
`endif

  assign pc_next = taken ? branch_target : pc_plus4;
  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_PC;
      cnt_reg      <= '0;
      pc_valid_reg <= 1'b0;
      halted_reg   <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_RUN: begin
          if (!stall) begin
            if (misaligned) begin
              state_reg    <= S_FAULT;
              pc_valid_reg <= 1'b0;
              halted_reg   <= 1'b0;
              fault_reg    <= 1'b1;
            end else begin
              pc_reg  <= pc_next;
              cnt_reg <= cnt_inc;
              if (halt_req) begin
                state_reg    <= S_HALT;
                pc_valid_reg <= 1'b0;
                halted_reg   <= 1'b1;
              end
            end
          end
        end
        default: begin
          // IDLE, HALT and FAULT all leave only through start.
          if (start) begin
            state_reg    <= S_RUN;
            pc_reg       <= RESET_PC;
            cnt_reg      <= '0;
            pc_valid_reg <= 1'b1;
            halted_reg   <= 1'b0;
            fault_reg    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign pc          = pc_reg;
  assign pc_valid    = pc_valid_reg;
  assign halted      = halted_reg;
  assign fault       = fault_reg;
  assign instr_count = cnt_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a behavioural model pushes expected outputs into a
// queue as each step is driven; they are popped and compared one cycle later.
module tb_pc_fetch_unit;

  localparam int PW = 10;
  localparam int CW = 4;
  localparam logic [PW-1:0] RPC = '0;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic          clk = 1'b0;
  logic          rst_n, start, stall, halt_req, branch, zero;
  logic [31:0]   immediate;
  logic [PW-1:0] pc;
  logic          pc_valid, halted, fault;
  logic [CW-1:0] instr_count;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic          v;
    logic          h;
    logic          f;
    logic [CW-1:0] c;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  int            m_st;
  logic [PW-1:0] m_pc;
  logic [CW-1:0] m_cnt;
  logic          m_f;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_req(halt_req),
    .branch(branch), .zero(zero), .immediate(immediate), .pc(pc), .pc_valid(pc_valid),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_pc = RPC; m_cnt = '0; m_f = 1'b0;
  endtask

  task automatic push_model();
    exp_t e;
    e.pc = m_pc;
    e.v  = (m_st == M_RUN);
    e.h  = (m_st == M_HALT);
    e.f  = m_f;
    e.c  = m_cnt;
    q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      cmp({tag, "_queue"}, 0, 1);
      return;
    end
    e = q.pop_front();
    cmp({tag, "_pc"},    32'(pc),          32'(e.pc));
    cmp({tag, "_valid"}, 32'(pc_valid),    32'(e.v));
    cmp({tag, "_halted"},32'(halted),      32'(e.h));
    cmp({tag, "_fault"}, 32'(fault),       32'(e.f));
    cmp({tag, "_count"}, 32'(instr_count), 32'(e.c));
    $display("txn %-10s pc=%0d valid=%0b halted=%0b fault=%0b count=%0d",
             tag, pc, pc_valid, halted, fault, instr_count);
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input string tag, input logic s, input logic st, input logic hr,
                      input logic br, input logic z, input logic [31:0] imm);
    logic [PW-1:0] tgt;
    logic          tk;
    start = s; stall = st; halt_req = hr; branch = br; zero = z; immediate = imm;
    if (m_st == M_RUN) begin
      if (!st) begin
        tk  = br & z;
        tgt = tk ? m_pc + imm[PW-1:0] : m_pc + 10'd4;
`ifdef MISALIGN_TRAP_EN
        if (tk && tgt[1:0] != 2'b00) begin
          m_st = M_FAULT; m_f = 1'b1;
        end else
`else
        tgt[1:0] = 2'b00;
`endif
        begin
          m_pc = tgt;
          if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
          if (hr) m_st = M_HALT;
        end
      end
    end else if (s) begin
      m_st = M_RUN; m_pc = RPC; m_cnt = '0; m_f = 1'b0;
    end
    push_model();
    @(posedge clk); #1;
    pop_check(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; halt_req = 0; branch = 0; zero = 0; immediate = '0;
    model_reset();
    #1;
    push_model(); pop_check("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("idle",      0, 0, 1, 1, 1, 32'd8);
    step("start",     1, 0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 5; i++) step("seq", 0, 0, 0, 0, 0, 32'd0);
    cmp("spec_pc20", 32'(pc), 32'd20);
    cmp("spec_cnt5", 32'(instr_count), 32'd5);
    cmp("spec_valid", 32'(pc_valid), 32'd1);

    step("br_to8",    0, 0, 0, 1, 1, -32'sd12);
    cmp("spec_pc8", 32'(pc), 32'd8);
    step("br_neg8",   0, 0, 0, 1, 1, -32'sd8);
    cmp("spec_pc0", 32'(pc), 32'd0);
    step("seq",       0, 0, 0, 0, 0, 32'd0);
    step("seq",       0, 0, 0, 0, 0, 32'd0);
    step("br_nz",     0, 0, 0, 1, 0, -32'sd8);
    cmp("spec_pc12", 32'(pc), 32'd12);
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 1, 1, 32'd100);
    cmp("spec_stall12", 32'(pc), 32'd12);
    step("resume",    0, 0, 0, 0, 0, 32'd0);
    cmp("spec_pc16", 32'(pc), 32'd16);
    step("halt",      0, 0, 1, 0, 0, 32'd0);
    cmp("spec_halt_pc", 32'(pc), 32'd20);
    cmp("spec_halted", 32'(halted), 32'd1);
    step("frozen",    0, 0, 1, 1, 1, 32'd4);
    step("restart",   1, 0, 0, 0, 0, 32'd0);

    step("br_wrap",   0, 0, 0, 1, 1, -32'sd4);
    cmp("spec_pc1020", 32'(pc), 32'd1020);
    step("wrap",      0, 0, 0, 0, 0, 32'd0);
    step("start_run", 1, 0, 0, 0, 0, 32'd0);
    step("halt_stl",  0, 1, 1, 0, 0, 32'd0);
    step("halt_go",   0, 0, 1, 0, 0, 32'd0);
    step("restart",   1, 0, 0, 0, 0, 32'd0);
    step("seq",       0, 0, 0, 0, 0, 32'd0);
    step("misalign",  0, 0, 0, 1, 1, 32'd6);
`ifdef MISALIGN_TRAP_EN
    cmp("spec_fault_pc", 32'(pc), 32'd4);
    step("fault_hold", 0, 0, 1, 0, 0, 32'd0);
    step("fault_clr",  1, 0, 0, 0, 0, 32'd0);
`else
    cmp("spec_align_pc", 32'(pc), 32'd8);
`endif

    for (int i = 0; i < 18; i++) step("sat", 0, 0, 0, 0, 0, 32'd0);
    cmp("spec_sat", 32'(instr_count), 32'(2**CW - 1));

    rst_n = 1'b0;
    #2;
    model_reset();
    push_model(); pop_check("async_rst");
    rst_n = 1'b1;
    step("post_rst",  0, 0, 0, 0, 0, 32'd0);
    step("start",     1, 0, 0, 0, 0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
